// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_next;

    // Returns {borrow_out, difference} of one full-subtractor cell.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    assign {br_next, d_bit} = full_sub(a_sh[0], b_sh[0], br);
    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    res  <= {d_bit, res[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff <= {d_bit, res[WIDTH-1:1]};
                        bout <= br_next;
                        done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // br here is the borrow into the MSB.
                        ovf  <= br ^ br_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations against
// an arithmetic reference model (covers ovf when SERIAL_SUB_OVF_EN is defined).
module tb_serial_subtractor;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain modular and signed integer arithmetic.
    task automatic model(input int x, input int y, input int bi);
        int sx;
        int sy;
        int sres;
        exp_diff = W'((x - y - bi) & MASK);
        exp_bout = (x < (y + bi));
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        sres = sx - sy - bi;
        exp_ovf = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
    endtask

    // One operation; inputs are scrambled after acceptance to prove they are latched.
    task automatic run_op(input int x, input int y, input int bi);
        int cycles;
        logic [W-1:0] old_diff;
        logic         old_bout;
        old_diff = exp_diff;
        old_bout = exp_bout;
        a = W'(x); b = W'(y); bin = bi[0]; start = 1'b1;
        tick();
        start = 1'b0;
        model(x, y, bi);
        cycles = 0;
        while (done !== 1'b1 && cycles < 3 * W) begin
            vectors++;
            if (busy !== 1'b1 || diff !== old_diff || bout !== old_bout) begin
                errors++;
                $display("FAIL busy_hold cyc=%0d busy=%b diff=%h bout=%b required busy=1 diff=%h bout=%b",
                         cycles, busy, diff, bout, old_diff, old_bout);
            end
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            cycles++;
            tick();
        end
        vectors++;
        if (cycles !== W) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d", cycles, W);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL result %0d-%0d-%0d done=%b busy=%b diff=%h bout=%b required done=1 busy=0 diff=%h bout=%b",
                     x, y, bi, done, busy, diff, bout, exp_diff, exp_bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf %0d-%0d-%0d got=%b required=%b", x, y, bi, ovf, exp_ovf);
        end
`endif
        tick();
        vectors++;
        if (done !== 1'b0 || diff !== exp_diff || bout !== exp_bout) begin
            errors++;
            $display("FAIL done_pulse done=%b diff=%h bout=%b required done=0 diff=%h bout=%b",
                     done, diff, bout, exp_diff, exp_bout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b diff=%h bout=%b required all 0", busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b required=0", ovf);
        end
`endif
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    endtask

    task automatic test_directed();
        run_op(7, 3, 0);
        run_op(3, 5, 0);
        run_op(0, 0, 1);
        run_op(15, 15, 1);
        run_op(0, 15, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(MASK)), int'($urandom_range(MASK)), int'($urandom_range(1)));
    endtask

    task automatic test_back_to_back();
        int last;
        int pulses;
        last = -1; pulses = 0;
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 3 * (W + 1); c++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                vectors++;
                if (diff !== 4'b0101 || bout !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result diff=%h bout=%b required diff=5 bout=0", diff, bout);
                end
                if (last >= 0) begin
                    vectors++;
                    if (c - last !== W + 1) begin
                        errors++;
                        $display("FAIL b2b_period got=%0d required=%0d", c - last, W + 1);
                    end
                end
                last = c;
            end
        end
        start = 1'b0;
        vectors++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d required=3", pulses);
        end
        // Drain the operation accepted alongside the final done pulse.
        for (int c = 0; c < W + 1; c++) tick();
        exp_diff = 4'b0101; exp_bout = 1'b0; model(9, 4, 0);
    endtask

    task automatic test_start_while_busy();
        int cycles;
        int extra;
        a = 4'd12; b = 4'd2; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        tick(); tick(); cycles = 2;
        a = 4'd1; b = 4'd1; start = 1'b1;
        tick(); cycles++;
        start = 1'b0;
        while (done !== 1'b1 && cycles < 3 * W) begin
            tick(); cycles++;
        end
        vectors++;
        if (cycles !== W || diff !== 4'b1010 || bout !== 1'b0) begin
            errors++;
            $display("FAIL busy_start cyc=%0d diff=%h bout=%b required cyc=%0d diff=a bout=0",
                     cycles, diff, bout, W);
        end
        extra = 0;
        for (int c = 0; c < 2 * W; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_start_extra activity=%0d required=0", extra);
        end
        model(12, 2, 0);
    endtask

    task automatic test_reset_mid();
        int pulses;
        a = 4'd15; b = 4'd1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b diff=%h bout=%b required all 0", busy, done, diff, bout);
        end
        pulses = 0;
        for (int c = 0; c < W + 3; c++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || diff !== '0) begin
            errors++;
            $display("FAIL reset_mid_done pulses=%0d diff=%h required 0 and 0", pulses, diff);
        end
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
        run_op(15, 1, 0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        run_op(7, 15, 0);
        run_op(2, 1, 0);
        run_op(8, 1, 0);
        run_op(8, 0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
